usb_in_arbiter: RTL and testbench

USB_IN_ARBITER -- requirements
Module: usb_in_arbiter

---
 rtl/usb_in_arbiter.sv | 134 +++++++++++++
 tb/tb_usb_in_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_in_arbiter.sv
// Round-robin arbiter that merges NUM_REQ byte streams onto one CDC IN channel.
// A grant is held for a whole message, capped at MAX_LEN bytes, and data flows combinationally while granted.
module usb_in_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_LEN = 16
) (
  input  logic                   clk_app,
  input  logic                   rstn_i,
  input  logic                   usb_configured_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [7:0]             in_data_o,
  output logic                   in_valid_o,
  input  logic                   in_ready_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   trunc_o
);

  localparam int         IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            trunc_q, trunc_d;

  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   gnt_nxt;
  logic [NUM_REQ-1:0] gnt_oh;
  logic            g_valid;
  logic            g_last;
  logic [7:0]      g_data;
  logic            active;
  logic            xfer_go;
  logic [7:0]      cnt_inc;

  // First valid requester at or above rr_q, wrapping around.
  always_comb begin
    logic [IW-1:0] cand;
    cand      = '0;
    sel_found = 1'b0;
    sel_idx   = rr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(rr_q) + i) % NUM_REQ);
      if (!sel_found && req_valid_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_oh  = '0;
    g_data  = 8'h00;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_q == IW'(k)) begin
        gnt_oh[k] = 1'b1;
        g_data    = req_data_i[8*k +: 8];
        g_valid   = req_valid_i[k];
        g_last    = req_last_i[k];
      end
    end
  end

  assign gnt_nxt = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
  assign cnt_inc = cnt_q + 8'd1;

  // Dropping configuration gates the datapath in the same cycle.
  assign active  = (state_q == XFER) && usb_configured_i;
  assign xfer_go = active && g_valid && in_ready_i;

  assign in_valid_o  = active && g_valid;
  assign in_data_o   = in_valid_o ? g_data : 8'h00;
  assign req_ready_o = active ? (gnt_oh & {NUM_REQ{in_ready_i}}) : '0;
  assign grant_o     = (state_q == XFER) ? gnt_oh : '0;
  assign trunc_o     = trunc_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    trunc_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (usb_configured_i && sel_found) begin
          state_d = XFER;
          gnt_d   = sel_idx;
          cnt_d   = 8'd0;
        end
      end
      XFER: begin
        if (!usb_configured_i) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (xfer_go) begin
          cnt_d = cnt_inc;
          if (g_last || (cnt_inc == MAX_LEN_B)) begin
            state_d = IDLE;
            rr_d    = gnt_nxt;
            cnt_d   = 8'd0;
            trunc_d = !g_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_app or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= 8'd0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Bench for usb_in_arbiter: message-level reference model compared every cycle, directed scenarios, random traffic.
module tb_usb_in_arbiter;
  localparam int N  = 4;
  localparam int ML = 16;

  logic          clk;
  logic          rstn;
  logic          cfg;
  logic [N-1:0]  vld;
  logic [8*N-1:0] dat;
  logic [N-1:0]  lst;
  logic [N-1:0]  rdy_o;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  grant;
  logic          trunc;

  usb_in_arbiter #(.NUM_REQ(N), .MAX_LEN(ML)) dut (
    .clk_app          (clk),
    .rstn_i           (rstn),
    .usb_configured_i (cfg),
    .req_valid_i      (vld),
    .req_data_i       (dat),
    .req_last_i       (lst),
    .req_ready_o      (rdy_o),
    .in_data_o        (in_data),
    .in_valid_o       (in_valid),
    .in_ready_i       (in_ready),
    .grant_o          (grant),
    .trunc_o          (trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int m_owner;   // -1 when nobody owns the channel
  int m_cnt;
  int m_rr;
  bit m_trunc;
  int m_xfers = 0;
  int d_xfers = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic m_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_rr    = 0;
    m_trunc = 0;
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_gnt, e_rdy;
    logic         e_val;
    logic [7:0]   e_dat;
    e_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e_val = (m_owner >= 0) && cfg && vld[m_owner];
    e_dat = e_val ? dat[8*m_owner +: 8] : 8'h00;
    e_rdy = ((m_owner >= 0) && cfg && in_ready) ? (N'(1) << m_owner) : '0;
    chk("grant", grant, e_gnt);
    chk("in_valid", in_valid, e_val);
    chk("in_data", in_data, e_dat);
    chk("req_ready", rdy_o, e_rdy);
    chk("trunc", trunc, m_trunc);
  endtask

  // Message-level rules applied once per rising edge.
  task automatic m_step();
    bit tr;
    bit found;
    int c;
    tr = 0;
    if (!rstn) begin
      m_reset();
      return;
    end
    if (m_owner < 0) begin
      if (cfg && vld != 0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (!found && vld[c]) begin
            found   = 1;
            m_owner = c;
          end
        end
        m_cnt = 0;
      end
    end else if (!cfg) begin
      m_owner = -1;
      m_cnt   = 0;
    end else if (vld[m_owner] && in_ready) begin
      m_xfers++;
      m_cnt++;
      if (lst[m_owner] || m_cnt == ML) begin
        tr      = !lst[m_owner];
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
        m_cnt   = 0;
      end
    end
    m_trunc = tr;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    if (!rstn) m_reset();
    #1;
    check_outputs();
    if (in_valid && in_ready) d_xfers++;
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    vld  = '0;
    lst  = '0;
    cycle();
    cycle();
    rstn = 1'b1;
  endtask

  initial begin
    logic [N-1:0] tbl [10];
    int b;
    int guard;
    bit acc;
    rstn = 1'b0; cfg = 1'b0; vld = '0; dat = '0; lst = '0; in_ready = 1'b0;
    m_reset();
    @(negedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_valid", in_valid, 0);
    chk("rst_data", in_data, 0);
    chk("rst_ready", rdy_o, 0);
    chk("rst_trunc", trunc, 0);
    @(negedge clk);
    do_reset();

    // Single requester 2, three-byte message
    cfg = 1'b1; in_ready = 1'b1; vld = 4'b0100; dat[23:16] = 8'hA1;
    #1 chk("r29_idle_valid", in_valid, 0);
    cycle();
    #1 chk("r29_grant", grant, 4'b0100);
    chk("r29_byte1", in_data, 8'hA1);
    cycle();
    dat[23:16] = 8'hA2; cycle();
    dat[23:16] = 8'hA3; lst = 4'b0100; cycle();
    vld = '0; lst = '0;
    #1 chk("r29_release", grant, 0);
    cycle();
    vld = 4'b1111; cycle();
    #1 chk("r29_rr3", grant, 4'b1000);
    lst = 4'b1111; cycle();
    vld = '0; lst = '0; cycle();

    // All four requesters, single-byte messages
    do_reset();
    tbl = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    cfg = 1'b1; in_ready = 1'b1; vld = 4'b1111; lst = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      #1 chk("r30_order", grant, tbl[i]);
      cycle();
    end
    vld = '0; lst = '0; cycle();

    // Requester 1 streams 20 bytes, truncated at 16
    do_reset();
    vld = 4'b0010; lst = '0;
    cycle();
    for (int i = 1; i <= 16; i++) begin
      dat[15:8] = 8'(i);
      cycle();
    end
    dat[15:8] = 8'd17;
    #1 chk("r31_trunc_hi", trunc, 1);
    chk("r31_released", grant, 0);
    cycle();
    #1 chk("r31_regrant", grant, 4'b0010);
    chk("r31_trunc_lo", trunc, 0);
    for (int i = 17; i <= 20; i++) begin
      dat[15:8] = 8'(i);
      lst = (i == 20) ? 4'b0010 : 4'b0000;
      cycle();
    end
    vld = '0; lst = '0; cycle();
    #1 chk("r31_done", grant, 0);

    // in_ready toggling during a 4-byte message
    do_reset();
    vld = 4'b0001; dat[7:0] = 8'hB0; cycle();
    b = 0; guard = 0;
    while (b < 4 && guard < 20) begin
      in_ready = (guard % 2 == 0);
      dat[7:0] = 8'hB0 + 8'(b);
      lst = (b == 3) ? 4'b0001 : 4'b0000;
      #1 chk("r32_data", in_data, 8'hB0 + 8'(b));
      acc = in_ready;
      cycle();
      if (acc) b++;
      guard++;
    end
    chk("r32_all_bytes", b, 4);
    vld = '0; lst = '0; in_ready = 1'b1; cycle();

    // Configuration dropped mid-message, rr pointer preserved
    do_reset();
    vld = 4'b0010; lst = 4'b0010; cycle(); cycle();
    vld = 4'b0100; lst = '0; cycle(); cycle();
    cfg = 1'b0;
    #1 chk("r33_valid_off", in_valid, 0);
    chk("r33_ready_off", rdy_o, 0);
    cycle();
    #1 chk("r33_grant_off", grant, 0);
    chk("r33_no_trunc", trunc, 0);
    vld = 4'b1111; cycle();
    cfg = 1'b1; cycle();
    #1 chk("r33_rr_kept", grant, 4'b0100);
    lst = 4'b1111; cycle();
    vld = '0; lst = '0; cycle();

    // Reset pulse during a transfer
    vld = 4'b0100; cycle(); cycle();
    vld = 4'b0010; cycle(); cycle();
    rstn = 1'b0;
    #1 chk("r34_grant", grant, 0);
    chk("r34_valid", in_valid, 0);
    chk("r34_data", in_data, 0);
    chk("r34_ready", rdy_o, 0);
    cycle();
    rstn = 1'b1; vld = 4'b1111; cycle();
    #1 chk("r34_from0", grant, 4'b0001);
    lst = 4'b1111; cycle();
    vld = '0; lst = '0; cycle();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rstn     = ($urandom_range(0, 499) != 0);
      cfg      = ($urandom_range(0, 99) != 0);
      in_ready = ($urandom_range(0, 3) != 0);
      dat      = {$urandom(), $urandom()} & {(8*N){1'b1}};
      for (int k = 0; k < N; k++) begin
        vld[k] = ($urandom_range(0, 3) != 0);
        lst[k] = ($urandom_range(0, 7) == 0);
      end
      cycle();
    end

    chk("xfer_count", d_xfers, m_xfers);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
